code_step_sequencer: RTL
========================

Name: code_step_sequencer

Overview:
- Upstream stage for the 3-to-8 decoder. Generates the 3-bit select code that drives the decoder's in1/in2/in3 inputs.
- Steps the code at a fixed prescaled rate.
- A single debounced push-button starts, pauses and resumes stepping.
- A direction input selects up or down counting. The result is a running-light pattern on the decoder's one-hot LED outputs.

Parameters:
- CNT_MAX, 24_999_999: prescaler terminal count. One step every CNT_MAX+1 clocks (0.5 s at 50 MHz).
- DEB_MAX, 999_999: debounce terminal count. Key must be stable for DEB_MAX+1 clocks (20 ms at 50 MHz).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw push-button, active-low, asynchronous to sys_clk, bouncy.
- dir  input  1  0 = count up, 1 = count down; sampled at each step.
- code1  output  1  code bit 2 (MSB); connects to decoder in1.
- code2  output  1  code bit 1; connects to decoder in2.
- code3  output  1  code bit 0 (LSB); connects to decoder in3.
- step_pulse  output  1  high for exactly one clock, coincident with the first cycle each new code value is visible.
- running  output  1  high while in state RUN.

Behaviour:
- Reset values: {code1,code2,code3}=3'b000, step_pulse=0, running=0, state=IDLE, prescaler=0, debounce counter=0, stable key=1, sync FFs=1.
- Input sync: key_in passes through 2 flip-flops before any use.
- Debounce:
  - Counter clears to 0 whenever synced key equals the stable key.
  - Otherwise it increments. On the cycle it equals DEB_MAX, stable key takes the synced value and the counter clears.
  - key_press = one-clock pulse on a stable-key 1->0 transition. Release generates nothing.
- FSM states and transitions (all others hold):
  - IDLE: on key_press -> RUN.
  - RUN: on key_press -> PAUSE.
  - PAUSE: on key_press -> RUN.
  - IDLE is reachable only through reset.
- Prescaler:
  - Counts 0..CNT_MAX only in RUN; held at 0 in IDLE/PAUSE.
  - tick is asserted when prescaler==CNT_MAX and state==RUN; the prescaler then wraps to 0.
  - Entering RUN always starts at prescaler 0, so the first step comes CNT_MAX+1 clocks after entry.
- Step:
  - On the tick edge, code <= code+1 (dir=0) or code-1 (dir=1), modulo 8.
  - Wrap: 3'b111 + 1 = 3'b000; 3'b000 - 1 = 3'b111.
  - step_pulse is registered high in the same edge and cleared on the next.
- Simultaneous key_press and tick: the state transition wins. RUN->PAUSE suppresses the step (code unchanged, no step_pulse, prescaler cleared).
- PAUSE holds code. Resume continues from the held code; there is no reset to 0.
- dir change mid-period: takes effect at the next tick only.
- Reset mid-operation: the edge with sys_rst=1 forces all reset values regardless of state. Any key_press in that cycle is discarded.
- Key-to-state latency: state changes on the 2+DEB_MAX+2-th rising edge after key_in settles low (2 sync, DEB_MAX+1 debounce, 1 edge detect).
- Outputs are all registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro PINGPONG_EN.
- Defined:
  - dir input is ignored.
  - Internal direction register resets to up.
  - Stepping up from 3'b111 reverses: that step yields 3'b110 and direction becomes down.
  - Stepping down from 3'b000 yields 3'b001 and direction becomes up.
  - Direction is held through PAUSE.
  - Sequence from reset: 0,1,...,7,6,...,0,1,...
- Undefined: modulo-8 wrap controlled by dir as above. No internal direction register is synthesised.

Test Plan (CNT_MAX=3, DEB_MAX=3):
- Reset, then key_in held low 10 clocks with dir=0 -> running=1 on the 7th edge after key_in low. Code steps 0->1->2 every 4 clocks, with a one-clock step_pulse at each change.
- RUN with dir=0 through code 7 -> next step gives 3'b000. Then dir=1 -> steps 0->7->6.
- key_in bouncing (toggling every 2 clocks for 12 clocks, then stable low) -> exactly one key_press, one state change, no extra steps.
- key_press lands on the same edge as tick in RUN -> state PAUSE, code unchanged, step_pulse=0. Second press -> RUN, first step exactly 4 clocks later from the held code.
- sys_rst asserted for 1 clock while code=5 in RUN -> next cycle code=0, running=0, step_pulse=0, IDLE, and no steps without a new press.
- With PINGPONG_EN, run 16 ticks -> code sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2. dir toggled randomly has no effect.

Source files
------------

// File: rtl/code_step_sequencer.sv
// Steps a 3-bit decoder select code at a prescaled rate; one debounced key starts/pauses/resumes. PINGPONG_EN: bounce 0..7..0 instead of dir-controlled wrap.
// Latency: key to state change 2+DEB_MAX+2 clocks; first step CNT_MAX+1 clocks after entering RUN; all outputs registered.
// Backpressure: none, free-running.
module code_step_sequencer #(
    parameter int CNT_MAX = 24_999_999,
    parameter int DEB_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    input  logic dir,
    output logic code1,
    output logic code2,
    output logic code3,
    output logic step_pulse,
    output logic running
);
    localparam int PW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int DW = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(CNT_MAX);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [DW-1:0] DEB_TOP = DW'(DEB_MAX);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            key_s1, key_s2, key_stable, key_stable_d;
    logic [DW-1:0]   deb_cnt;
    logic [PW-1:0]   presc;
    logic [2:0]      code, code_nxt;
    logic            key_press, tick, do_step;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_s1       <= 1'b1;
            key_s2       <= 1'b1;
            key_stable   <= 1'b1;
            key_stable_d <= 1'b1;
            deb_cnt      <= '0;
        end else begin
            key_s1       <= key_in;
            key_s2       <= key_s1;
            key_stable_d <= key_stable;
            if (key_s2 == key_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_TOP) begin
                key_stable <= key_s2;
                deb_cnt    <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end
    end

    // Press is the falling edge of the debounced key; release is ignored.
    assign key_press = key_stable_d & ~key_stable;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_press) state_nxt = RUN;
            RUN:     if (key_press) state_nxt = PAUSE;
            PAUSE:   if (key_press) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign tick    = (state == RUN) && (presc == PRE_TOP);
    // A press on the tick edge wins: the step is dropped.
    assign do_step = tick && !key_press;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || state != RUN || key_press || tick) presc <= '0;
        else                                              presc <= presc + PRE_ONE;
    end

`ifdef PINGPONG_EN
    logic up, up_nxt;
    logic unused_dir;
    assign unused_dir = dir;

    always_comb begin
        code_nxt = code;
        up_nxt   = up;
        if (up) begin
            if (code == 3'd7) begin
                code_nxt = 3'd6;
                up_nxt   = 1'b0;
            end else begin
                code_nxt = code + 3'd1;
            end
        end else begin
            if (code == 3'd0) begin
                code_nxt = 3'd1;
                up_nxt   = 1'b1;
            end else begin
                code_nxt = code - 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)      up <= 1'b1;
        else if (do_step) up <= up_nxt;
    end
`else
    assign code_nxt = dir ? (code - 3'd1) : (code + 3'd1);
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            code       <= 3'd0;
            step_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            step_pulse <= do_step;
            running    <= (state_nxt == RUN);
            if (do_step) code <= code_nxt;
        end
    end

    assign {code1, code2, code3} = code;
endmodule
